deserializer: RTL



---
 rtl/deserializer.sv | 118 +++++++++++
 1 files changed

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel receiver for the guard-bit serial link
module deserializer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             frame_err,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             done_q, done_d;
    logic             gbad_q, gbad_d;

    logic [WIDTH-1:0] sin_msb;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    // Shift-in value: new bit enters at the MSB so the first data bit ends up at bit 0
    always_comb begin
        sin_msb            = '0;
        sin_msb[WIDTH-1]   = sin;
        shifted            = (shreg_q >> 1) | sin_msb;
        last_bit           = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and datapath updates; a sampled start always wins over the state transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        done_d  = done_q;
        gbad_d  = gbad_q;

        case (state_q)
            IDLE: begin
            end
            GUARD: begin
                gbad_d  = sin;
                state_d = SHIFT;
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    data_d  = shifted;
                    ferr_d  = gbad_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start aborts any partial frame (completion on the same edge still lands above)
        if (start) begin
            state_d = GUARD;
            shreg_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
            gbad_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            gbad_q  <= gbad_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
